// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame width, default bit period
// and the receiver FSM state type.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 434;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..PERIOD-1 while enabled and flags terminal count
// at either the half period (start-bit centre) or the full period.
module uart_bit_timer #(
    parameter int PERIOD = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    input  logic half,
    output logic tc
);

    localparam int W = $clog2(PERIOD);
    localparam logic [W-1:0] FULL_TC = W'(PERIOD - 1);
    localparam logic [W-1:0] HALF_TC = W'(PERIOD / 2 - 1);

    logic [W-1:0] count;

    // Counter wraps to zero on every terminal count so each sample restarts the period.
    assign tc = enable && (count == (half ? HALF_TC : FULL_TC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: detects the start edge, samples mid-bit, assembles
// LSB-first bytes and presents them on a valid/ready output with overrun tracking.
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = uart_pkg::DATA_BITS
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 RxFilt,
    input  logic                 RxReady,
    input  logic                 ClrOvr,
    output logic [DATA_BITS-1:0] RxData,
    output logic                 RxValid,
    output logic                 FrameErr,
    output logic                 Overrun,
    output logic                 Busy,
    output uart_pkg::rx_state_t  DbgState
);

    import uart_pkg::rx_state_t;
    import uart_pkg::ST_IDLE;
    import uart_pkg::ST_START;
    import uart_pkg::ST_DATA;
    import uart_pkg::ST_STOP;
    import uart_pkg::ST_WAIT_HIGH;

    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

    rx_state_t              state;
    rx_state_t              next_state;
    logic                   prev_rx;
    logic [IW-1:0]          bit_idx;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   tmr_clear;
    logic                   tmr_en;
    logic                   tmr_half;
    logic                   tmr_tc;
    logic                   good_frame;
    logic                   handshake;

    uart_bit_timer #(.PERIOD(CLKS_PER_BIT)) u_timer (
        .clk    (Clk),
        .rst_n  (Rst_n),
        .clear  (tmr_clear),
        .enable (tmr_en),
        .half   (tmr_half),
        .tc     (tmr_tc)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      if (prev_rx && !RxFilt) next_state = ST_START;
            ST_START:     if (tmr_tc) next_state = RxFilt ? ST_IDLE : ST_DATA;
            ST_DATA:      if (tmr_tc && bit_idx == LAST_BIT) next_state = ST_STOP;
            ST_STOP:      if (tmr_tc) next_state = RxFilt ? ST_IDLE : ST_WAIT_HIGH;
            ST_WAIT_HIGH: if (RxFilt) next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        Busy      = (state != ST_IDLE);
        tmr_clear = (state == ST_IDLE) || (state == ST_WAIT_HIGH);
        tmr_en    = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
        tmr_half  = (state == ST_START);
    end

    assign DbgState = state;

    // Output handshake: a byte is transferred in any cycle where RxValid and RxReady
    // are both 1; RxData is held stable while RxValid=1 and the byte is unconsumed.
    assign handshake  = RxValid && RxReady;
    assign good_frame = (state == ST_STOP) && tmr_tc && RxFilt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            prev_rx   <= 1'b1;
            bit_idx   <= '0;
            shift_reg <= '0;
            FrameErr  <= 1'b0;
        end else begin
            prev_rx  <= RxFilt;
            FrameErr <= (state == ST_STOP) && tmr_tc && !RxFilt;
            if (state == ST_START && tmr_tc) begin
                bit_idx <= '0;
            end else if (state == ST_DATA && tmr_tc) begin
                shift_reg <= {RxFilt, shift_reg[DATA_BITS-1:1]};
                bit_idx   <= bit_idx + 1'b1;
            end
        end
    end

    // A byte completing while the previous one is still held and not being taken is dropped.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            RxData  <= '0;
            RxValid <= 1'b0;
            Overrun <= 1'b0;
        end else begin
            if (good_frame && (!RxValid || handshake)) begin
                RxData  <= shift_reg;
                RxValid <= 1'b1;
            end else if (handshake) begin
                RxValid <= 1'b0;
            end
            if (good_frame && RxValid && !RxReady) Overrun <= 1'b1;
            else if (ClrOvr)                       Overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at 16 clocks per bit: frame timing, false start,
// framing error, overrun, handshake collision and mid-frame reset.
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    localparam int CPB = 16;

    logic       Clk;
    logic       Rst_n;
    logic       RxFilt;
    logic       RxReady;
    logic       ClrOvr;
    logic [7:0] RxData;
    logic       RxValid;
    logic       FrameErr;
    logic       Overrun;
    logic       Busy;
    rx_state_t  DbgState;

    int tests_run    = 0;
    int tests_failed = 0;

    logic valid_hist [0:255];
    logic ferr_hist  [0:255];
    logic busy_hist  [0:255];

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .RxFilt   (RxFilt),
        .RxReady  (RxReady),
        .ClrOvr   (ClrOvr),
        .RxData   (RxData),
        .RxValid  (RxValid),
        .FrameErr (FrameErr),
        .Overrun  (Overrun),
        .Busy     (Busy),
        .DbgState (DbgState)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Drives one frame (or a short low pulse when short_low>0) starting at cycle N = offset 0;
    // history index k holds outputs seen during cycle N+k.
    task automatic drive_frame(input logic [7:0] data, input logic stop, input int n_cycles,
                               input int short_low, input logic rdy_default,
                               input int ready_at, input int clr_at);
        logic [9:0] frame;
        int s;
        frame = {stop, data, 1'b0};
        for (int c = 0; c < n_cycles; c++) begin
            s = c / CPB;
            if (short_low > 0) RxFilt = (c < short_low) ? 1'b0 : 1'b1;
            else               RxFilt = (s < 10) ? frame[s] : 1'b1;
            RxReady = (c == ready_at) ? 1'b1 : rdy_default;
            ClrOvr  = (c == clr_at);
            tick();
            valid_hist[c+1] = RxValid;
            ferr_hist[c+1]  = FrameErr;
            busy_hist[c+1]  = Busy;
        end
        RxReady = 1'b0;
        ClrOvr  = 1'b0;
        RxFilt  = 1'b1;
    endtask

    task automatic consume();
        RxReady = 1'b1;
        tick();
        RxReady = 1'b0;
    endtask

    task automatic pulse_clr();
        ClrOvr = 1'b1;
        tick();
        ClrOvr = 1'b0;
    endtask

    function automatic int count_hist(input int which, input int n);
        int total;
        total = 0;
        for (int k = 1; k <= n; k++) begin
            if (which == 0 && valid_hist[k]) total++;
            if (which == 1 && ferr_hist[k])  total++;
        end
        return total;
    endfunction

    initial begin
        Rst_n   = 1'b0;
        RxFilt  = 1'b1;
        RxReady = 1'b0;
        ClrOvr  = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_valid",   32'(RxValid),  32'h0);
        check("rst_data",    32'(RxData),   32'h0);
        check("rst_ferr",    32'(FrameErr), 32'h0);
        check("rst_ovr",     32'(Overrun),  32'h0);
        check("rst_busy",    32'(Busy),     32'h0);
        check("rst_state",   32'(DbgState), 32'(ST_IDLE));
        Rst_n = 1'b1;
        repeat (3) tick();

        // Good frame 0xA5: byte appears exactly at N+153
        drive_frame(8'hA5, 1'b1, 180, 0, 1'b0, -1, -1);
        check("a5_busy_n1",   32'(busy_hist[1]),   32'h1);
        check("a5_valid_152", 32'(valid_hist[152]), 32'h0);
        check("a5_valid_153", 32'(valid_hist[153]), 32'h1);
        check("a5_busy_153",  32'(busy_hist[153]),  32'h0);
        check("a5_data",      32'(RxData),          32'hA5);
        check("a5_ferr",      32'(count_hist(1, 180)), 32'h0);
        check("a5_held",      32'(RxValid),         32'h1);
        consume();
        check("a5_consumed",  32'(RxValid),         32'h0);
        check("a5_data_keep", 32'(RxData),          32'hA5);

        // False start: 4 low cycles, back in IDLE by N+9
        drive_frame(8'h00, 1'b1, 30, 4, 1'b0, -1, -1);
        check("fs_busy_8",  32'(busy_hist[8]), 32'h1);
        check("fs_busy_9",  32'(busy_hist[9]), 32'h0);
        check("fs_valid",   32'(count_hist(0, 30)), 32'h0);
        check("fs_ferr",    32'(count_hist(1, 30)), 32'h0);

        // Bad stop bit on 0x3C: one-cycle FrameErr at N+153, Busy until line high
        drive_frame(8'h3C, 1'b0, 170, 0, 1'b0, -1, -1);
        check("fe_ferr_152",  32'(ferr_hist[152]), 32'h0);
        check("fe_ferr_153",  32'(ferr_hist[153]), 32'h1);
        check("fe_ferr_154",  32'(ferr_hist[154]), 32'h0);
        check("fe_ferr_cnt",  32'(count_hist(1, 170)), 32'h1);
        check("fe_valid",     32'(count_hist(0, 170)), 32'h0);
        check("fe_busy_160",  32'(busy_hist[160]), 32'h1);
        check("fe_busy_161",  32'(busy_hist[161]), 32'h0);
        check("fe_data_keep", 32'(RxData),         32'hA5);

        // Back-to-back 0x11, 0x22 with no consumer: second byte dropped
        drive_frame(8'h11, 1'b1, 160, 0, 1'b0, -1, -1);
        check("ov_ovr_first", 32'(Overrun), 32'h0);
        drive_frame(8'h22, 1'b1, 160, 0, 1'b0, -1, -1);
        check("ov_data",   32'(RxData),  32'h11);
        check("ov_valid",  32'(RxValid), 32'h1);
        check("ov_ovr",    32'(Overrun), 32'h1);
        pulse_clr();
        check("ov_clr",       32'(Overrun), 32'h0);
        check("ov_clr_data",  32'(RxData),  32'h11);
        check("ov_clr_valid", 32'(RxValid), 32'h1);
        consume();
        check("ov_consumed",  32'(RxValid), 32'h0);

        // Handshake in the exact completion cycle of the second byte
        drive_frame(8'h11, 1'b1, 160, 0, 1'b0, -1, -1);
        drive_frame(8'h22, 1'b1, 160, 0, 1'b0, 152, -1);
        check("hs_valid_153", 32'(valid_hist[153]), 32'h1);
        check("hs_data",      32'(RxData),  32'h22);
        check("hs_valid",     32'(RxValid), 32'h1);
        check("hs_ovr",       32'(Overrun), 32'h0);

        // Overrun set coinciding with ClrOvr: set wins
        drive_frame(8'h44, 1'b1, 160, 0, 1'b0, -1, 152);
        check("sw_ovr",  32'(Overrun), 32'h1);
        check("sw_data", 32'(RxData),  32'h22);

        // Reset during data bit 3, then a clean 0x5A
        drive_frame(8'h0F, 1'b1, 70, 0, 1'b0, -1, -1);
        check("mr_busy_pre", 32'(Busy), 32'h1);
        Rst_n = 1'b0;
        #1;
        check("mr_valid", 32'(RxValid),  32'h0);
        check("mr_data",  32'(RxData),   32'h0);
        check("mr_ovr",   32'(Overrun),  32'h0);
        check("mr_ferr",  32'(FrameErr), 32'h0);
        check("mr_busy",  32'(Busy),     32'h0);
        repeat (3) @(posedge Clk);
        #1;
        check("mr_busy_hold", 32'(Busy), 32'h0);
        Rst_n = 1'b1;
        repeat (5) tick();
        check("mr_idle_after", 32'(Busy), 32'h0);
        drive_frame(8'h5A, 1'b1, 170, 0, 1'b0, -1, -1);
        check("mr_5a_valid_153", 32'(valid_hist[153]), 32'h1);
        check("mr_5a_data",      32'(RxData),  32'h5A);
        check("mr_5a_ferr",      32'(count_hist(1, 170)), 32'h0);
        check("mr_5a_ovr",       32'(Overrun), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
